wbu_tx_uart: RTL



---
 rtl/wbu_uart_pkg.sv | 21 ++
 rtl/wbu_tx_uart_if.sv | 12 +
 rtl/wbu_baud_tick.sv | 31 +++
 rtl/wbu_tx_uart.sv | 120 ++++++++++++
 4 files changed

// File: rtl/wbu_uart_pkg.sv
// Shared UART definitions: state encoding, bit counts and line idle level.
// WBU_TX_UART_PARITY_EN adds the PARITY bit to the frame length.
package wbu_uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   localparam int DATA_BITS = 8;
`ifdef WBU_TX_UART_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/wbu_tx_uart_if.sv
// Byte-stream handshake from the output chain plus the serial line it feeds.
interface wbu_tx_uart_if;
   import wbu_uart_pkg::*;

   logic                 i_stb;
   logic [DATA_BITS-1:0] i_data;
   logic                 o_busy;
   logic                 o_uart_tx;

   modport master (output i_stb, output i_data, input o_busy, input o_uart_tx);
   modport slave  (input i_stb, input i_data, output o_busy, output o_uart_tx);
endinterface

// File: rtl/wbu_baud_tick.sv
// Loadable baud down-counter; o_tick marks the final cycle of a bit period,
// o_last the cycle before it. Holds at zero until restarted.
module wbu_baud_tick #(
   parameter int CLOCKS_PER_BAUD = 868,
   parameter int CKW             = 24
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_restart,
   output logic o_tick,
   output logic o_last
);

   localparam logic [CKW-1:0] RELOAD = CKW'(CLOCKS_PER_BAUD - 1);
   localparam logic [CKW-1:0] ONE    = CKW'(1);

   logic [CKW-1:0] cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         cnt <= '0;
      else if (i_restart)
         cnt <= RELOAD;
      else if (cnt != '0)
         cnt <= cnt - ONE;
   end

   assign o_tick = (cnt == '0);
   assign o_last = (cnt == ONE);

endmodule

// File: rtl/wbu_tx_uart.sv
// Debug-bus UART transmitter: 8N1 framing with busy back-pressure.
// Define WBU_TX_UART_PARITY_EN to insert an even-parity bit before STOP.
module wbu_tx_uart
   import wbu_uart_pkg::*;
#(
   parameter int CLOCKS_PER_BAUD = 868,
   parameter int CKW             = 24
) (
   input  logic          i_clk,
   input  logic          i_rst,
   wbu_tx_uart_if.slave  bus
);

   tx_state_t            state, state_n;
   logic [2:0]           bit_idx, bit_idx_n;
   logic [DATA_BITS-1:0] shift, shift_n;
   logic                 tx_r, tx_n;
   logic                 busy_r, busy_n;
   logic                 restart, tick, last, accept;
`ifdef WBU_TX_UART_PARITY_EN
   logic                 par, par_n;
`endif

   assign accept = bus.i_stb && !busy_r;

   wbu_baud_tick #(
      .CLOCKS_PER_BAUD (CLOCKS_PER_BAUD),
      .CKW             (CKW)
   ) u_baud (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_restart (restart),
      .o_tick    (tick),
      .o_last    (last)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state   <= IDLE;
         bit_idx <= '0;
         shift   <= '1;
         tx_r    <= LINE_IDLE;
         busy_r  <= 1'b0;
`ifdef WBU_TX_UART_PARITY_EN
         par     <= 1'b0;
`endif
      end else begin
         state   <= state_n;
         bit_idx <= bit_idx_n;
         shift   <= shift_n;
         tx_r    <= tx_n;
         busy_r  <= busy_n;
`ifdef WBU_TX_UART_PARITY_EN
         par     <= par_n;
`endif
      end
   end

   always_comb begin
      state_n   = state;
      bit_idx_n = bit_idx;
      shift_n   = shift;
      restart   = 1'b0;
`ifdef WBU_TX_UART_PARITY_EN
      par_n     = accept ? ^bus.i_data : par;
`endif
      case (state)
         IDLE: if (accept) begin
            state_n = START;
            shift_n = bus.i_data;
            restart = 1'b1;
         end
         START: if (tick) begin
            state_n   = DATA;
            bit_idx_n = '0;
            restart   = 1'b1;
         end
         DATA: if (tick) begin
            shift_n = {1'b1, shift[DATA_BITS-1:1]};
            restart = 1'b1;
            if (bit_idx == 3'(DATA_BITS - 1))
`ifdef WBU_TX_UART_PARITY_EN
               state_n = PARITY;
`else
               state_n = STOP;
`endif
            else
               bit_idx_n = bit_idx + 3'd1;
         end
         PARITY: if (tick) begin
            state_n = STOP;
            restart = 1'b1;
         end
         STOP: if (accept) begin
            // busy is only low on the final STOP cycle, so this chains frames gaplessly
            state_n = START;
            shift_n = bus.i_data;
            restart = 1'b1;
         end else if (tick) begin
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      // Line and busy are computed one cycle ahead so both come straight from flops
      case (state_n)
         START:   tx_n = 1'b0;
         DATA:    tx_n = shift_n[0];
`ifdef WBU_TX_UART_PARITY_EN
         PARITY:  tx_n = par_n;
`endif
         default: tx_n = LINE_IDLE;
      endcase
      busy_n = !((state_n == IDLE) || (state_n == STOP && !restart && last));
   end

   assign bus.o_busy    = busy_r;
   assign bus.o_uart_tx = tx_r;

endmodule
